// File: rtl/run_ctrl_if.sv
// run_ctrl_if: Start/Done handshake and fetch-control signals between the bench and run_ctrl.
interface run_ctrl_if;
    logic        Start;
    logic        Halt;
    logic        PcLoad;
    logic [9:0]  PcLoadVal;
    logic        Run;
    logic        Done;
    logic        Timeout;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCount;
    modport master (
        output Start, Halt,
        input  PcLoad, PcLoadVal, Run, Done, Timeout, ProgIdx, CycleCount
    );
    modport slave (
        input  Start, Halt,
        output PcLoad, PcLoadVal, Run, Done, Timeout, ProgIdx, CycleCount
    );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: program-run controller answering the bench's Start/Done handshake for the fetch stage.
module run_ctrl #(
    parameter int          NUM_PROGS      = 3,
    parameter logic [9:0]  PROG_BASE0     = 10'd0,
    parameter logic [9:0]  PROG_BASE1     = 10'd0,
    parameter logic [9:0]  PROG_BASE2     = 10'd0,
    parameter logic [9:0]  PROG_BASE3     = 10'd0,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input logic       Clk,
    input logic       Reset,
    run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
    localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);
    state_t          state, state_nxt;
    logic [1:0]      prog_idx;
    logic [15:0]     cycle_count;
    logic            timeout;
    logic            budget_spent;
    logic [3:0][9:0] bases;
    assign bases        = {PROG_BASE3, PROG_BASE2, PROG_BASE1, PROG_BASE0};
    assign budget_spent = cycle_count == TIMEOUT_CYCLES - 16'd1;
    always_ff @(posedge Clk)
        state <= Reset ? IDLE : state_nxt;
    // Start always wins: a restart in RUN beats Halt and the budget check
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.Start ? ARMED : IDLE;
            ARMED:   state_nxt = bus.Start ? ARMED : RUN;
            RUN:     state_nxt = bus.Start ? ARMED : (bus.Halt || budget_spent) ? DONE : RUN;
            default: state_nxt = bus.Start ? ARMED : DONE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prog_idx    <= 2'd0;
            cycle_count <= 16'd0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                ARMED: if (!bus.Start) begin
                    cycle_count <= 16'd0;
                    timeout     <= 1'b0;
                end
                RUN: begin
                    cycle_count <= cycle_count + 16'd1;
                    if (!bus.Start && !bus.Halt && budget_spent)
                        timeout <= 1'b1;
                end
                DONE: if (bus.Start) begin
                    prog_idx <= prog_idx == LAST_IDX ? 2'd0 : prog_idx + 2'd1;
                    timeout  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    assign bus.PcLoad     = state == ARMED;
    assign bus.Run        = state == RUN;
    assign bus.Done       = state == DONE;
    assign bus.PcLoadVal  = bases[prog_idx];
    assign bus.Timeout    = timeout;
    assign bus.ProgIdx    = prog_idx;
    assign bus.CycleCount = cycle_count;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl with a per-cycle reference model and literal spot checks.
module tb_run_ctrl;
    localparam int NP = 3;
    localparam int TO = 8;
    localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
    logic Clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_ph, m_idx, m_cnt;
    logic m_to;
    run_ctrl_if bus ();
    run_ctrl #(
        .NUM_PROGS(NP), .PROG_BASE0(10'd0), .PROG_BASE1(10'd100), .PROG_BASE2(10'd200),
        .PROG_BASE3(10'd300), .TIMEOUT_CYCLES(16'(TO))
    ) dut (.Clk(Clk), .Reset(rst), .bus(bus));
    always #5 Clk = ~Clk;
    // Model tracks the run lifecycle: armed while Start is held, counts RUN cycles, then finished
    always @(posedge Clk) begin
        if (rst) begin
            m_ph <= P_IDLE; m_idx <= 0; m_cnt <= 0; m_to <= 1'b0;
        end else if (m_ph == P_IDLE) begin
            if (bus.Start) m_ph <= P_ARMED;
        end else if (m_ph == P_ARMED) begin
            if (!bus.Start) begin m_ph <= P_RUN; m_cnt <= 0; m_to <= 1'b0; end
        end else if (m_ph == P_RUN) begin
            m_cnt <= m_cnt + 1;
            if (bus.Start) m_ph <= P_ARMED;
            else if (bus.Halt || m_cnt + 1 == TO) begin m_ph <= P_DONE; m_to <= !bus.Halt; end
        end else if (bus.Start) begin
            m_ph <= P_ARMED; m_idx <= (m_idx + 1) % NP; m_to <= 1'b0;
        end
    end
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic cyc(input int n);
        if (n > 0) repeat (n) @(posedge Clk);
        #1;
    endtask
    task automatic arm(input int hold, input int base);
        bus.Start = 1'b1;
        cyc(1);
        chk("arm_pcload", 16'(bus.PcLoad), 16'd1);
        chk("arm_pcval", 16'(bus.PcLoadVal), 16'(base));
        cyc(hold - 1);
        bus.Start = 1'b0;
        cyc(1);
    endtask
    task automatic halt_in(input int n);
        for (int i = 0; i < n; i++) begin
            chk("halt_run", 16'(bus.Run), 16'd1);
            if (i == n - 1) bus.Halt = 1'b1;
            cyc(1);
            bus.Halt = 1'b0;
        end
        chk("halt_run_off", 16'(bus.Run), 16'd0);
        chk("halt_done", 16'(bus.Done), 16'd1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        fork
            forever begin
                @(negedge Clk);
                if (chk_en) begin
                    chk("m_pcload", 16'(bus.PcLoad), 16'(m_ph == P_ARMED));
                    chk("m_run", 16'(bus.Run), 16'(m_ph == P_RUN));
                    chk("m_done", 16'(bus.Done), 16'(m_ph == P_DONE));
                    chk("m_pcval", 16'(bus.PcLoadVal), 16'(m_idx * 100));
                    chk("m_idx", 16'(bus.ProgIdx), 16'(m_idx));
                    chk("m_cnt", bus.CycleCount, 16'(m_cnt));
                    chk("m_to", 16'(bus.Timeout), 16'(m_to));
                end
            end
        join_none
        bus.Start = 1'b0;
        bus.Halt  = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_run", 16'(bus.Run), 16'd0);
        chk("rst_done", 16'(bus.Done), 16'd0);
        chk("rst_pcval", 16'(bus.PcLoadVal), 16'd0);
        chk("rst_cnt", bus.CycleCount, 16'd0);
        arm(3, 0);
        halt_in(5);
        chk("p0_cnt", bus.CycleCount, 16'd5);
        chk("p0_to", 16'(bus.Timeout), 16'd0);
        chk("p0_idx", 16'(bus.ProgIdx), 16'd0);
        arm(1, 100);
        halt_in(2);
        chk("p1_idx", 16'(bus.ProgIdx), 16'd1);
        chk("p1_cnt", bus.CycleCount, 16'd2);
        arm(2, 200);
        halt_in(1);
        chk("p2_idx", 16'(bus.ProgIdx), 16'd2);
        chk("p2_cnt", bus.CycleCount, 16'd1);
        arm(1, 0);
        chk("wrap_idx", 16'(bus.ProgIdx), 16'd0);
        cyc(7);
        chk("to_last_run", 16'(bus.Run), 16'd1);
        cyc(1);
        chk("to_done", 16'(bus.Done), 16'd1);
        chk("to_flag", 16'(bus.Timeout), 16'd1);
        chk("to_cnt", bus.CycleCount, 16'd8);
        bus.Start = 1'b1;
        cyc(1);
        chk("to_cleared", 16'(bus.Timeout), 16'd0);
        bus.Start = 1'b0;
        cyc(1);
        halt_in(8);
        chk("edge_to", 16'(bus.Timeout), 16'd0);
        chk("edge_cnt", bus.CycleCount, 16'd8);
        arm(1, 200);
        cyc(2);
        bus.Start = 1'b1;
        bus.Halt  = 1'b1;
        cyc(1);
        bus.Halt  = 1'b0;
        chk("restart_pcload", 16'(bus.PcLoad), 16'd1);
        chk("restart_done", 16'(bus.Done), 16'd0);
        chk("restart_idx", 16'(bus.ProgIdx), 16'd2);
        bus.Start = 1'b0;
        cyc(1);
        chk("restart_cnt", bus.CycleCount, 16'd0);
        halt_in(1);
        arm(1, 0);
        halt_in(1);
        arm(1, 100);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_run", 16'(bus.Run), 16'd0);
        chk("mid_rst_done", 16'(bus.Done), 16'd0);
        chk("mid_rst_idx", 16'(bus.ProgIdx), 16'd0);
        chk("mid_rst_cnt", bus.CycleCount, 16'd0);
        bus.Halt = 1'b1;
        cyc(2);
        bus.Halt = 1'b0;
        chk("idle_halt_done", 16'(bus.Done), 16'd0);
        chk("idle_halt_pcload", 16'(bus.PcLoad), 16'd0);
        arm(1, 0);
        halt_in(1);
        arm(4, 100);
        chk("held_idx", 16'(bus.ProgIdx), 16'd1);
        cyc(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Program-run controller that sits between the test bench and the fetch stage: the processor-side responder to the bench's Start/Done handshake. It holds the program counter at the selected program's base address while Start is high and enables execution when Start falls. It ends the run on a decoded halt or on a cycle-budget timeout, reports Done to the bench, and advances to the next program on the following Start.

## Interface
Parameters:
- NUM_PROGS, 3: number of programs in the series, 1..4
- PROG_BASE0, 10'd0: start address of program 0
- PROG_BASE1, 10'd0: start address of program 1
- PROG_BASE2, 10'd0: start address of program 2
- PROG_BASE3, 10'd0: start address of program 3
- TIMEOUT_CYCLES, 16'd4096: maximum RUN cycles per program, 1..65535

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  bench request; level, held high for one or more cycles
- Halt  in  1  halt instruction decoded this cycle; sampled only in RUN
- PcLoad  out  1  forces the fetch PC to PcLoadVal this edge
- PcLoadVal  out  10  base address of the current program
- Run  out  1  execution enable for fetch, register file and memory writes
- Done  out  1  run complete, to the bench
- Timeout  out  1  last run ended by the cycle budget, not by Halt
- ProgIdx  out  2  index of the current program
- CycleCount  out  16  RUN cycles consumed by the current or last run

## Operation
- States: IDLE, ARMED, RUN, DONE. This is a Moore machine: every output decodes from registered state.
- Reset (any state) sets: IDLE, ProgIdx=0, CycleCount=0, Timeout=0. Resulting outputs: PcLoad=0, Run=0, Done=0, PcLoadVal=PROG_BASE0.
- IDLE: Start=1 -> ARMED.
- ARMED:
  - PcLoad=1, Run=0.
  - Start=1 -> stay in ARMED.
  - Start=0 -> RUN, CycleCount<=0, Timeout<=0.
- RUN:
  - Run=1, PcLoad=0. Each edge increments CycleCount.
  - Priority: Start=1 -> ARMED (restart same ProgIdx); else Halt=1 -> DONE; else CycleCount==TIMEOUT_CYCLES-1 -> DONE with Timeout<=1; else stay.
- DONE:
  - Done=1, Run=0. CycleCount and Timeout are frozen.
  - Start=1 -> ARMED. Same edge: ProgIdx<=ProgIdx+1, wrapping NUM_PROGS-1 -> 0; Timeout<=0.
- PcLoadVal = PROG_BASE[ProgIdx], combinational from the ProgIdx register.
- ProgIdx changes only on the DONE->ARMED edge and on Reset.

## Timing
- Start rising in IDLE or DONE: PcLoad=1 from the next cycle. Done falls on the same edge.
- Start falling: Run=1 and PcLoad=0 from the next cycle. The PC then equals the base address in the first RUN cycle.
- Halt sampled in RUN cycle N (N counted from 1): Done=1 and Run=0 from cycle N+1, with CycleCount=N.
- No Halt: the TIMEOUT_CYCLES-th RUN cycle is the last one. Done=1, Timeout=1 and CycleCount=TIMEOUT_CYCLES from the next cycle.
- Halt in the timeout cycle: Timeout=0, CycleCount=TIMEOUT_CYCLES.
- Halt and Start in the same RUN cycle: Start wins, next state ARMED, ProgIdx unchanged.
- Halt outside RUN is ignored.
- CycleCount cannot overflow, because TIMEOUT_CYCLES ≤ 65535.
- Reset mid-RUN: state is IDLE next cycle. Run drops immediately; no Done pulse.
- Start held high across several cycles in DONE: ProgIdx advances exactly once.

## Test plan
- Reset, then Start high 3 cycles, low. Halt in 5th RUN cycle -> Run=1 for exactly 5 cycles; PcLoad=1 during ARMED with PcLoadVal=PROG_BASE0; Done=1, CycleCount=5, Timeout=0, ProgIdx=0.
- With PROG_BASE1=10'd100, PROG_BASE2=10'd200: run three programs back to back -> PcLoadVal 0,100,200. A 4th Start -> ProgIdx=0, PcLoadVal=0.
- TIMEOUT_CYCLES=8, Halt never asserted -> Done after 8 RUN cycles, Timeout=1, CycleCount=8. Next Start clears Timeout.
- TIMEOUT_CYCLES=8, Halt in RUN cycle 8 -> Done=1, Timeout=0, CycleCount=8.
- Start in RUN cycle 3 together with Halt -> returns to ARMED, ProgIdx unchanged, no Done. On release CycleCount restarts from 0.
- Reset in RUN cycle 4 of program 1 -> next cycle IDLE, Run=0, Done=0, ProgIdx=0, CycleCount=0.
